// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with frame-aligned
// req/ack shadow updates and a dead band at the start of every digit slot.
module seven_seg_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYC    = 1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] digits,
  input  logic [3:0]  dig_en,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic        frame_end,
  output logic [3:0]  an,
  output logic [6:0]  ca
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] DeadEnd = CntW'(DEAD_CYC);

  typedef enum logic [0:0] {StDead, StLit} state_e;

  state_e          st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     sh_dig_q, sh_dig_d;
  logic [3:0]      sh_en_q, sh_en_d;
  logic [3:0]      an_d;
  logic [6:0]      ca_d;
  logic            frame_end_d;
  logic            upd_ack_d;
  logic [3:0]      nib;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] seg;
    unique case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Outputs are computed from next-state values so the registered pins line up
  // with the counter/index they describe in the same cycle.
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    idx_d = (cnt_q == CntMax) ? idx_q + 2'd1 : idx_q;

    upd_ack_d = frame_end && upd_req;
    sh_dig_d  = upd_ack_d ? digits : sh_dig_q;
    sh_en_d   = upd_ack_d ? dig_en : sh_en_q;

    st_d = st_q;
    unique case (st_q)
      StDead:  if (cnt_d == DeadEnd) st_d = StLit;
      default: if (cnt_d == '0) st_d = StDead;
    endcase

    nib  = sh_dig_d[idx_d*4 +: 4];
    an_d = 4'b1111;
    ca_d = 7'b1111111;
    if (st_d == StLit && sh_en_d[idx_d]) begin
      an_d[idx_d] = 1'b0;
      ca_d        = hex_decode(nib);
    end

    frame_end_d = (idx_d == 2'd3) && (cnt_d == CntMax);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q      <= StDead;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      sh_dig_q  <= 16'h0000;
      sh_en_q   <= 4'b0000;
      an        <= 4'b1111;
      ca        <= 7'b1111111;
      upd_ack   <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_dig_q  <= sh_dig_d;
      sh_en_q   <= sh_en_d;
      an        <= an_d;
      ca        <= ca_d;
      upd_ack   <= upd_ack_d;
      frame_end <= frame_end_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed, table-driven bench for seven_seg_scan_controller (REFRESH_DIV=8, DEAD_CYC=2).
module tb_seven_seg_scan_controller;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  dig_en;
  logic        upd_req;
  logic        upd_ack;
  logic        frame_end;
  logic [3:0]  an;
  logic [6:0]  ca;

  int tests = 0;
  int fails = 0;

  seven_seg_scan_controller #(
    .REFRESH_DIV(8),
    .DEAD_CYC   (2)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .digits   (digits),
    .dig_en   (dig_en),
    .upd_req  (upd_req),
    .upd_ack  (upd_ack),
    .frame_end(frame_end),
    .an       (an),
    .ca       (ca)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      en;
    logic [3:0][3:0] an;   // index = slot
    logic [3:0][6:0] ca;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Anode one-hot-low or all-high; cathodes dark whenever anodes are all high.
  always @(negedge clk) begin
    check("an_onehot_ca_dark",
          {31'd0, ($countones(~an) <= 1) && (an != 4'b1111 || ca == 7'b1111111)}, 32'd1);
  end

  // Returns at the negedge where upd_ack is seen (frame offset 0).
  task automatic do_update(input logic [15:0] d, input logic [3:0] e, input bit drop);
    bit got;
    bit fe_prev;
    digits  = d;
    dig_en  = e;
    upd_req = 1'b1;
    got     = 1'b0;
    fe_prev = frame_end;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (upd_ack) got = 1'b1;
      else fe_prev = frame_end;
    end
    check("upd_ack_seen", {31'd0, got}, 32'd1);
    check("ack_after_frame_end", {31'd0, fe_prev}, 32'd1);
    check("frame_end_low_at_ack", {31'd0, frame_end}, 32'd0);
    if (drop) upd_req = 1'b0;
  endtask

  initial begin
    logic [3:0] ean;
    logic [6:0] eca;
    int s;
    int c;

    vecs[0] = '{16'h0003, 4'b0001, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0110000}};
    vecs[1] = '{16'hF210, 4'b1111, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0001110, 7'b0100100, 7'b1111001, 7'b1000000}};
    vecs[2] = '{16'h8A5B, 4'b1010, {4'b0111, 4'b1111, 4'b1101, 4'b1111},
                {7'b0000000, 7'b1111111, 7'b0010010, 7'b1111111}};
    vecs[3] = '{16'h76EC, 4'b0101, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111111, 7'b0000010, 7'b1111111, 7'b1000110}};
    vecs[4] = '{16'h49DA, 4'b1111, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0011001, 7'b0010000, 7'b0100001, 7'b0001000}};
    vecs[5] = '{16'h0000, 4'b0000, {4'b1111, 4'b1111, 4'b1111, 4'b1111},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}};

    clr     = 1'b0;
    digits  = 16'h0000;
    dig_en  = 4'b0000;
    upd_req = 1'b0;

    // Reset state, then dark display until the first update
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_ca", {25'd0, ca}, 32'h7F);
    check("rst_ack", {31'd0, upd_ack}, 32'd0);
    check("rst_fe", {31'd0, frame_end}, 32'd0);
    clr = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("dark_an", {28'd0, an}, 32'hF);
      check("dark_ack", {31'd0, upd_ack}, 32'd0);
    end

    // Table: load each vector and walk one full frame from the ack cycle
    for (int v = 0; v < 6; v++) begin
      do_update(vecs[v].digits, vecs[v].en, 1'b1);
      for (int off = 0; off < 32; off++) begin
        if (off > 0) @(negedge clk);
        s = off / 8;
        c = off % 8;
        ean = (c < 2) ? 4'b1111 : vecs[v].an[s];
        eca = (c < 2) ? 7'b1111111 : vecs[v].ca[s];
        check("scan_an", {28'd0, an}, {28'd0, ean});
        check("scan_ca", {25'd0, ca}, {25'd0, eca});
        check("scan_fe", {31'd0, frame_end}, {31'd0, off == 31});
        check("scan_ack", {31'd0, upd_ack}, {31'd0, off == 0});
      end
    end

    // Held request: reloaded and acked again one frame later
    do_update(16'h1111, 4'b1111, 1'b0);
    digits = 16'h2222;
    for (int off = 1; off <= 64; off++) begin
      @(negedge clk);
      if (off == 2) check("held_old_ca", {25'd0, ca}, {25'd0, 7'b1111001});
      if (off == 31) check("held_fe", {31'd0, frame_end}, 32'd1);
      check("held_ack", {31'd0, upd_ack}, {31'd0, off == 32});
      if (off == 32) upd_req = 1'b0;
      if (off == 34) begin
        check("held_new_an", {28'd0, an}, {28'd0, 4'b1110});
        check("held_new_ca", {25'd0, ca}, {25'd0, 7'b0100100});
      end
    end

    // Mid-frame reset during slot 2 LIT with a pending request
    repeat (19) @(negedge clk);
    check("pre_rst_an", {28'd0, an}, {28'd0, 4'b1011});
    check("pre_rst_ca", {25'd0, ca}, {25'd0, 7'b0100100});
    digits  = 16'h3333;
    upd_req = 1'b1;
    #2 clr = 1'b0;
    #1;
    check("async_rst_an", {28'd0, an}, 32'hF);
    check("async_rst_ca", {25'd0, ca}, 32'h7F);
    check("async_rst_ack", {31'd0, upd_ack}, 32'd0);
    check("async_rst_fe", {31'd0, frame_end}, 32'd0);
    repeat (2) @(negedge clk);
    upd_req = 1'b0;
    clr     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_rst_ack", {31'd0, upd_ack}, 32'd0);
      check("post_rst_dark", {28'd0, an}, 32'hF);
    end
    do_update(16'h0003, 4'b0001, 1'b1);
    repeat (2) @(negedge clk);
    check("relit_an", {28'd0, an}, {28'd0, 4'b1110});
    check("relit_ca", {25'd0, ca}, {25'd0, 7'b0110000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
